// File: rtl/spi_txn_seq.sv
// Burst sequencer that drives write/read enables to a downstream SPI controller.
// Each transaction is framed by SETUP and GAP phases; reads complete on a synchronized receive flag.
module spi_txn_seq #(
   parameter logic [15:0] TX_HOLD    = 16'd5000,
   parameter logic [15:0] RX_TIMEOUT = 16'd20000,
   parameter logic [7:0]  GAP        = 8'd200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cmd_rw,
   input  logic [3:0] burst_len,
   input  logic       abort,
   input  logic       receive_status,
   output logic       spi_tx_en,
   output logic       spi_rx_en,
   output logic       mode_select,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [4:0] xfer_count
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned XFER_W = 5;
   localparam int unsigned SYNC_W = 3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_TX    = 3'd2,
      S_RX    = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [LEN_W-1:0]    remaining_q, remaining_d;
   logic                rw_q, rw_d;
   logic                tx_en_q, tx_en_d;
   logic                rx_en_q, rx_en_d;
   logic                mode_q, mode_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [XFER_W-1:0]   xfer_q, xfer_d;
   logic [SYNC_W-1:0]   sync_q, sync_d;
   logic                rx_rise;
   state_e              post_xfer_s;

   // Two synchronizer stages plus one history flop for rising-edge detection
   assign sync_d  = {sync_q[SYNC_W-2:0], receive_status};
   assign rx_rise = sync_q[1] & ~sync_q[2];

   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      remaining_d = remaining_q;
      rw_d        = rw_q;
      mode_d      = mode_q;
      err_d       = err_q;
      xfer_d      = xfer_q;
      // SETUP is the last idle cycle between transactions, so the GAP state covers the rest
      post_xfer_s = S_GAP;
      if (GAP == 8'd1) begin
         post_xfer_s = (remaining_q > LEN_W'(1)) ? S_SETUP : S_DONE;
      end

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (burst_len != '0)) begin
                  state_d     = S_SETUP;
                  rw_d        = cmd_rw;
                  mode_d      = cmd_rw;
                  remaining_d = burst_len;
                  xfer_d      = '0;
                  err_d       = 1'b0;
               end
            end
            S_SETUP: begin
               cnt_d   = '0;
               state_d = rw_q ? S_RX : S_TX;
            end
            S_TX: begin
               if (cnt_q == (TX_HOLD - CNT_W'(1))) begin
                  cnt_d       = '0;
                  xfer_d      = xfer_q + XFER_W'(1);
                  remaining_d = remaining_q - LEN_W'(1);
                  state_d     = post_xfer_s;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_RX: begin
               // A completion edge beats a timeout landing in the same cycle
               if (rx_rise) begin
                  cnt_d       = '0;
                  xfer_d      = xfer_q + XFER_W'(1);
                  remaining_d = remaining_q - LEN_W'(1);
                  state_d     = post_xfer_s;
               end else if (cnt_q == (RX_TIMEOUT - CNT_W'(1))) begin
                  cnt_d   = '0;
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_GAP: begin
               if (cnt_q == ({8'd0, GAP} - CNT_W'(2))) begin
                  cnt_d   = '0;
                  state_d = (remaining_q != '0) ? S_SETUP : S_DONE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Outputs are decoded from the next state so they register alongside it
      tx_en_d = (state_d == S_TX);
      rx_en_d = (state_d == S_RX);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         remaining_q <= '0;
         rw_q        <= 1'b0;
         tx_en_q     <= 1'b0;
         rx_en_q     <= 1'b0;
         mode_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         xfer_q      <= '0;
         sync_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         remaining_q <= remaining_d;
         rw_q        <= rw_d;
         tx_en_q     <= tx_en_d;
         rx_en_q     <= rx_en_d;
         mode_q      <= mode_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         xfer_q      <= xfer_d;
         sync_q      <= sync_d;
      end
   end

   assign spi_tx_en   = tx_en_q;
   assign spi_rx_en   = rx_en_q;
   assign mode_select = mode_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_spi_txn_seq.sv
// Directed bench for spi_txn_seq with short phases (TX_HOLD=4, RX_TIMEOUT=50, GAP=3).
module tb_spi_txn_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       cmd_rw;
   logic [3:0] burst_len;
   logic       abort;
   logic       receive_status;
   logic       spi_tx_en;
   logic       spi_rx_en;
   logic       mode_select;
   logic       busy;
   logic       done;
   logic       err;
   logic [4:0] xfer_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] tx_tr, rx_tr, busy_tr, done_tr;
   int rx_cnt, tx_cnt, done_cnt, done_idx, act_cnt;

   spi_txn_seq #(
      .TX_HOLD   (16'd4),
      .RX_TIMEOUT(16'd50),
      .GAP       (8'd3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cmd_rw        (cmd_rw),
      .burst_len     (burst_len),
      .abort         (abort),
      .receive_status(receive_status),
      .spi_tx_en     (spi_tx_en),
      .spi_rx_en     (spi_rx_en),
      .mode_select   (mode_select),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .xfer_count    (xfer_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_tx"},   32'(spi_tx_en),   32'd0);
      chk({pfx, "_rx"},   32'(spi_rx_en),   32'd0);
      chk({pfx, "_mode"}, 32'(mode_select), 32'd0);
      chk({pfx, "_busy"}, 32'(busy),        32'd0);
      chk({pfx, "_done"}, 32'(done),        32'd0);
      chk({pfx, "_err"},  32'(err),         32'd0);
      chk({pfx, "_xfer"}, 32'(xfer_count),  32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cmd_rw = 1'b0; burst_len = 4'd0;
      abort = 1'b0; receive_status = 1'b0;
      tick(); tick();
      chk_reset_vals("reset");
      rst_n = 1'b1;
      tick();

      // Write burst of two: 4-cycle pulses, 3 low cycles between, done at edge 14
      tx_tr = '0; rx_tr = '0; busy_tr = '0; done_tr = '0;
      start = 1'b1; cmd_rw = 1'b0; burst_len = 4'd2;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0) start = 1'b0;
         tx_tr[i] = spi_tx_en; rx_tr[i] = spi_rx_en;
         busy_tr[i] = busy; done_tr[i] = done;
      end
      chk("wr_tx_trace",   tx_tr,   32'h0000_0F1E);
      chk("wr_rx_trace",   rx_tr,   32'h0);
      chk("wr_busy_trace", busy_tr, 32'h0000_7FFF);
      chk("wr_done_trace", done_tr, 32'h0000_4000);
      chk("wr_xfer",       32'(xfer_count), 32'd2);
      chk("wr_err",        32'(err),        32'd0);

      // Read with response 10 cycles into RX; rx_en drops 3 edges later
      tx_tr = '0; rx_tr = '0; done_tr = '0;
      start = 1'b1; cmd_rw = 1'b1; burst_len = 4'd1;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (i == 0) start = 1'b0;
         if (i == 10) receive_status = 1'b1;
         tx_tr[i] = spi_tx_en; rx_tr[i] = spi_rx_en; done_tr[i] = done;
      end
      chk("rd_rx_trace",   rx_tr,   32'h0000_1FFE);
      chk("rd_tx_trace",   tx_tr,   32'h0);
      chk("rd_done_trace", done_tr, 32'h0000_8000);
      chk("rd_xfer",       32'(xfer_count),  32'd1);
      chk("rd_err",        32'(err),         32'd0);
      chk("rd_mode_hold",  32'(mode_select), 32'd1);
      receive_status = 1'b0;
      repeat (4) tick();

      // Read timeout: 50 cycles of rx_en, then err and done, remaining reads skipped
      rx_cnt = 0; tx_cnt = 0; done_cnt = 0; done_idx = -1;
      start = 1'b1; cmd_rw = 1'b1; burst_len = 4'd3;
      for (int i = 0; i < 56; i++) begin
         tick();
         if (i == 0) start = 1'b0;
         if (spi_rx_en) rx_cnt++;
         if (spi_tx_en) tx_cnt++;
         if (done) begin done_cnt++; done_idx = i; end
      end
      chk("to_rx_cycles", 32'(rx_cnt),     32'd50);
      chk("to_tx_cycles", 32'(tx_cnt),     32'd0);
      chk("to_done_cnt",  32'(done_cnt),   32'd1);
      chk("to_done_edge", 32'(done_idx),   32'd51);
      chk("to_err",       32'(err),        32'd1);
      chk("to_xfer",      32'(xfer_count), 32'd0);
      chk("to_busy_end",  32'(busy),       32'd0);

      // Abort in the second TX of a 3-burst; err from the timeout is cleared on start
      tx_tr = '0; busy_tr = '0; done_tr = '0;
      start = 1'b1; cmd_rw = 1'b0; burst_len = 4'd3;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i == 0) start = 1'b0;
         if (i == 9) abort = 1'b0;
         tx_tr[i] = spi_tx_en; busy_tr[i] = busy; done_tr[i] = done;
         if (i == 8) abort = 1'b1;
      end
      chk("ab_tx_trace",   tx_tr,   32'h0000_011E);
      chk("ab_busy_trace", busy_tr, 32'h0000_01FF);
      chk("ab_done_trace", done_tr, 32'h0);
      chk("ab_xfer",       32'(xfer_count), 32'd1);
      chk("ab_err",        32'(err),        32'd0);

      // Zero-length start is ignored
      act_cnt = 0;
      start = 1'b1; cmd_rw = 1'b1; burst_len = 4'd0;
      tick();
      start = 1'b0;
      if (busy || done || spi_tx_en || spi_rx_en) act_cnt++;
      repeat (3) begin
         tick();
         if (busy || done || spi_tx_en || spi_rx_en) act_cnt++;
      end
      chk("len0_activity", 32'(act_cnt), 32'd0);

      // Start while busy does not disturb a single write
      tx_tr = '0; rx_tr = '0; busy_tr = '0; done_tr = '0;
      start = 1'b1; cmd_rw = 1'b0; burst_len = 4'd1;
      for (int i = 0; i < 12; i++) begin
         tick();
         start = 1'b0;
         if (i == 2) begin start = 1'b1; cmd_rw = 1'b1; burst_len = 4'd5; end
         tx_tr[i] = spi_tx_en; rx_tr[i] = spi_rx_en;
         busy_tr[i] = busy; done_tr[i] = done;
      end
      start = 1'b0;
      chk("bz_tx_trace",   tx_tr,   32'h0000_001E);
      chk("bz_rx_trace",   rx_tr,   32'h0);
      chk("bz_busy_trace", busy_tr, 32'h0000_00FF);
      chk("bz_done_trace", done_tr, 32'h0000_0080);
      chk("bz_mode",       32'(mode_select), 32'd0);
      chk("bz_xfer",       32'(xfer_count),  32'd1);

      // Reset in the middle of RX
      start = 1'b1; cmd_rw = 1'b1; burst_len = 4'd2;
      for (int i = 0; i < 6; i++) begin
         tick();
         start = 1'b0;
      end
      chk("mr_rx_pre",   32'(spi_rx_en),   32'd1);
      chk("mr_mode_pre", 32'(mode_select), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset_vals("mr");
      act_cnt = 0;
      repeat (6) begin
         tick();
         if (busy || done || spi_tx_en || spi_rx_en) act_cnt++;
      end
      chk("mr_post_activity", 32'(act_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
